reg_file_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register pending scoreboard, for the dual-issue / multi-cycle-writeback core.
- Generalises the single-issue 32x32, 2R/1W register file in width, depth, and read/write port count.
- Adds a scoreboard so decode can see which registers await writeback.
- Sits between decode (read ports, issue) and writeback (write ports).

---
 rtl/reg_file_mp.sv | 95 +++++++++
 tb/tb_reg_file_mp.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with a per-register pending scoreboard.
// Optional macro REGFILE_BYPASS_EN adds combinational write-to-read forwarding.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  output logic                   any_busy
);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Register 0 and anything past DEPTH are neither stored nor tracked.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(DEPTH));
  endfunction

  // Writes clear pending in port order; an issue applied last keeps the new producer pending.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && addr_ok(wr_addr[j*AW +: AW])) begin
        w_pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && addr_ok(iss_rd)) begin
      w_pend_nxt[iss_rd] = 1'b1;
    end
  end

  // Later write ports overwrite earlier ones on an address conflict.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && addr_ok(wr_addr[j*AW +: AW])) begin
          r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
      r_pend <= w_pend_nxt;
    end
  end

  assign any_busy = |r_pend;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_ok;

    assign w_addr = rd_addr[gi*AW +: AW];
    assign w_ok   = addr_ok(w_addr);

`ifdef REGFILE_BYPASS_EN
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;

    // Highest-index matching write port supplies the forwarded value.
    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
          w_hit = 1'b1;
          w_fwd = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    assign rd_data[gi*XLEN +: XLEN] = !w_ok ? '0 : (w_hit ? w_fwd : r_mem[w_addr]);
    assign rd_busy[gi] = w_ok && (w_hit ? (iss_en && (iss_rd == w_addr)) : r_pend[w_addr]);
`else
    assign rd_data[gi*XLEN +: XLEN] = w_ok ? r_mem[w_addr] : '0;
    assign rd_busy[gi] = w_ok && r_pend[w_addr];
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random + directed checks of reg_file_mp (default 2R/2W x32 and a 3R/1W x24 build)
// against an array-based reference model of the register file rules.
module tb_reg_file_mp;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  // Instance A: defaults (XLEN=32, DEPTH=32, NUM_RD=2, NUM_WR=2)
  logic [4:0]  a_ra [2];
  logic [1:0]  a_we;
  logic [4:0]  a_wa [2];
  logic [31:0] a_wd [2];
  logic        a_iss_en;
  logic [4:0]  a_iss_rd;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_any_busy;

  assign a_rd_addr = {a_ra[1], a_ra[0]};
  assign a_wr_addr = {a_wa[1], a_wa[0]};
  assign a_wr_data = {a_wd[1], a_wd[0]};

  reg_file_mp dut_a (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data),
    .rd_busy (a_rd_busy),
    .wr_en   (a_we),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .iss_en  (a_iss_en),
    .iss_rd  (a_iss_rd),
    .any_busy(a_any_busy)
  );

  // Instance B: DEPTH=24, NUM_RD=3, NUM_WR=1
  logic [4:0]  b_ra [3];
  logic        b_we;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        b_iss_en;
  logic [4:0]  b_iss_rd;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_any_busy;

  assign b_rd_addr = {b_ra[2], b_ra[1], b_ra[0]};

  reg_file_mp #(.DEPTH(24), .NUM_RD(3), .NUM_WR(1)) dut_b (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data),
    .rd_busy (b_rd_busy),
    .wr_en   (b_we),
    .wr_addr (b_wa),
    .wr_data (b_wd),
    .iss_en  (b_iss_en),
    .iss_rd  (b_iss_rd),
    .any_busy(b_any_busy)
  );

  // Reference model state
  logic [31:0] ma [32];
  logic [31:0] pa;
  logic [31:0] mb [24];
  logic [23:0] pb;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) ma[k] = '0;
    for (int k = 0; k < 24; k++) mb[k] = '0;
    pa = '0;
    pb = '0;
  endtask

  function automatic void exp_a(input logic [4:0] a, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (a != 0) begin
      d = ma[a];
      b = pa[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < 2; j++) begin
        if (a_we[j] && a_wa[j] == a) begin
          d = a_wd[j];
          b = a_iss_en && (a_iss_rd == a);
        end
      end
`endif
    end
  endfunction

  function automatic void exp_b(input logic [4:0] a, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (a != 0 && a < 24) begin
      d = mb[a];
      b = pb[a];
`ifdef REGFILE_BYPASS_EN
      if (b_we && b_wa == a) begin
        d = b_wd;
        b = b_iss_en && (b_iss_rd == a);
      end
`endif
    end
  endfunction

  task automatic check_all();
    logic [31:0] d;
    logic        b;
    for (int i = 0; i < 2; i++) begin
      exp_a(a_ra[i], d, b);
      chk("A_rd_data", 64'(a_rd_data[i*32 +: 32]), 64'(d));
      chk("A_rd_busy", 64'(a_rd_busy[i]), 64'(b));
    end
    chk("A_any_busy", 64'(a_any_busy), 64'(|pa));
    for (int i = 0; i < 3; i++) begin
      exp_b(b_ra[i], d, b);
      chk("B_rd_data", 64'(b_rd_data[i*32 +: 32]), 64'(d));
      chk("B_rd_busy", 64'(b_rd_busy[i]), 64'(b));
    end
    chk("B_any_busy", 64'(b_any_busy), 64'(|pb));
  endtask

  // Apply the spec's edge rules: writes in port order, then issue.
  task automatic upd_model();
    if (cpu_rst) begin
      clear_model();
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (a_we[j] && a_wa[j] != 0) begin
          ma[a_wa[j]] = a_wd[j];
          pa[a_wa[j]] = 1'b0;
        end
      end
      if (a_iss_en && a_iss_rd != 0) pa[a_iss_rd] = 1'b1;
      if (b_we && b_wa != 0 && b_wa < 24) begin
        mb[b_wa] = b_wd;
        pb[b_wa] = 1'b0;
      end
      if (b_iss_en && b_iss_rd != 0 && b_iss_rd < 24) pb[b_iss_rd] = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs set; returns just after the next falling edge.
  task automatic tick();
    #1;
    check_all();
    @(posedge cpu_clk);
    upd_model();
    @(negedge cpu_clk);
  endtask

  task automatic idle();
    a_we = '0;
    a_iss_en = 1'b0;
    b_we = 1'b0;
    b_iss_en = 1'b0;
  endtask

  initial begin
    clear_model();
    for (int i = 0; i < 2; i++) begin a_ra[i] = '0; a_wa[i] = '0; a_wd[i] = '0; end
    for (int i = 0; i < 3; i++) b_ra[i] = '0;
    b_wa = '0; b_wd = '0; a_iss_rd = '0; b_iss_rd = '0;
    idle();
    cpu_rst = 1'b1;

    // Reset state
    @(negedge cpu_clk);
    a_ra[0] = 5'd5; a_ra[1] = 5'd31;
    tick();
    cpu_rst = 1'b0;
    tick();

    // Register 0: write and issue ignored
    a_we[0] = 1'b1; a_wa[0] = 5'd0; a_wd[0] = 32'hFFFF_FFFF; a_ra[0] = 5'd0;
    tick();
    idle();
    a_iss_en = 1'b1; a_iss_rd = 5'd0;
    tick();
    idle();
    #1;
    chk("r0_data", 64'(a_rd_data[31:0]), 64'h0);
    chk("r0_busy", 64'(a_rd_busy[0]), 64'h0);
    chk("r0_any_busy", 64'(a_any_busy), 64'h0);

    // Write conflict: highest port wins
    a_we = 2'b11; a_wa[0] = 5'd7; a_wa[1] = 5'd7; a_wd[0] = 32'h11; a_wd[1] = 32'h22;
    tick();
    idle();
    a_ra[0] = 5'd7;
    #1;
    chk("conflict_r7", 64'(a_rd_data[31:0]), 64'h22);

    // Scoreboard
    a_iss_en = 1'b1; a_iss_rd = 5'd3;
    tick();
    idle();
    a_ra[0] = 5'd3;
    #1;
    chk("sb_busy_n1", 64'(a_rd_busy[0]), 64'h1);
    chk("sb_any_busy", 64'(a_any_busy), 64'h1);
    tick();
    tick();
    a_we[0] = 1'b1; a_wa[0] = 5'd3; a_wd[0] = 32'h55;
    tick();
    idle();
    #1;
    chk("sb_busy_clr", 64'(a_rd_busy[0]), 64'h0);
    chk("sb_data", 64'(a_rd_data[31:0]), 64'h55);
    a_we[1] = 1'b1; a_wa[1] = 5'd3; a_wd[1] = 32'h66; a_iss_en = 1'b1; a_iss_rd = 5'd3;
    tick();
    idle();
    #1;
    chk("sb_iss_wr_busy", 64'(a_rd_busy[0]), 64'h1);
    a_we[0] = 1'b1; a_wa[0] = 5'd3; a_wd[0] = 32'h77;
    tick();
    idle();

    // Read during write on r9
    a_we[0] = 1'b1; a_wa[0] = 5'd9; a_wd[0] = 32'h1;
    tick();
    a_wd[0] = 32'hA5A5; a_ra[1] = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_same_cycle", 64'(a_rd_data[63:32]), 64'hA5A5);
`else
    chk("rdw_same_cycle", 64'(a_rd_data[63:32]), 64'h1);
`endif
    tick();
    idle();
    #1;
    chk("rdw_next_cycle", 64'(a_rd_data[63:32]), 64'hA5A5);

    // Instance B: out-of-range address 30
    b_we = 1'b1; b_wa = 5'd30; b_wd = 32'hCAFE; b_iss_en = 1'b1; b_iss_rd = 5'd30;
    b_ra[0] = 5'd30;
    tick();
    idle();
    #1;
    chk("oor_data", 64'(b_rd_data[31:0]), 64'h0);
    chk("oor_busy", 64'(b_rd_busy[0]), 64'h0);
    chk("oor_any_busy", 64'(b_any_busy), 64'h0);
    for (int r = 1; r <= 3; r++) begin
      b_we = 1'b1; b_wa = 5'(r); b_wd = 32'h100 * r + 32'h1;
      tick();
    end
    idle();
    b_ra[0] = 5'd2; b_ra[1] = 5'd3; b_ra[2] = 5'd1;
    #1;
    chk("b_port0", 64'(b_rd_data[31:0]), 64'h201);
    chk("b_port1", 64'(b_rd_data[63:32]), 64'h301);
    chk("b_port2", 64'(b_rd_data[95:64]), 64'h101);

    // Asynchronous reset between edges
    a_we[0] = 1'b1; a_wa[0] = 5'd5; a_wd[0] = 32'hDEAD_BEEF;
    a_iss_en = 1'b1; a_iss_rd = 5'd6;
    tick();
    idle();
    a_ra[0] = 5'd5;
    #1;
    chk("pre_rst_r5", 64'(a_rd_data[31:0]), 64'hDEAD_BEEF);
    #1;
    cpu_rst = 1'b1;
    clear_model();
    #1;
    chk("rst_r5_data", 64'(a_rd_data[31:0]), 64'h0);
    chk("rst_r5_busy", 64'(a_rd_busy[0]), 64'h0);
    chk("rst_any_busy", 64'(a_any_busy), 64'h0);
    a_we[0] = 1'b1; a_wa[0] = 5'd5; a_wd[0] = 32'h1234;
    tick();
    cpu_rst = 1'b0;
    idle();
    #1;
    chk("rst_write_dropped", 64'(a_rd_data[31:0]), 64'h0);
    a_we[0] = 1'b1; a_wa[0] = 5'd5; a_wd[0] = 32'h77;
    tick();
    idle();
    #1;
    chk("first_write_after_rst", 64'(a_rd_data[31:0]), 64'h77);

    // Randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        a_ra[i] = 5'($urandom_range(0, 31));
        a_wa[i] = 5'($urandom_range(0, 7) + ($urandom_range(0, 3) == 0 ? 8 : 0));
        a_wd[i] = $urandom;
      end
      a_we     = 2'($urandom_range(0, 3));
      a_iss_en = ($urandom_range(0, 3) == 0);
      a_iss_rd = 5'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) b_ra[i] = 5'($urandom_range(0, 31));
      b_we     = ($urandom_range(0, 1) == 1);
      b_wa     = 5'($urandom_range(0, 31));
      b_wd     = $urandom;
      b_iss_en = ($urandom_range(0, 2) == 0);
      b_iss_rd = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
